frame_capture: RTL and testbench

- Receive end of the CLIO frame interface: captures the byte stream (FRAME, CCLK, 8-bit data) driven by the Frame_State transmitter.
- Frames are reg_length bytes long; reg_delay frames make one capture.
- Bytes are repacked into 16-bit words (first byte in the upper half) and buffered in a FIFO that the host reads over the ti_clk domain.
- Used for loopback self-test of the DAC path and for capturing interferometer frame data.

---
 rtl/frame_capture.sv | 236 +++++++++++++++++++++++
 tb/tb_frame_capture.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture.sv
// Receive end of the CLIO frame interface. Captures bytes strobed by CCLK
// while FRAME is high, packs them into 16-bit words (first byte in the upper
// half) and buffers them in a FIFO that the host drains on ti_clk.
module frame_capture #(
  parameter int FIFO_AW = 6,
  parameter bit SYNC_IN = 1'b1
) (
  input  logic              ti_clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [31:0]       reg_length,
  input  logic [31:0]       reg_delay,
  input  logic              FRAME,
  input  logic              CCLK,
  input  logic [7:0]        din,
  input  logic              rd_en,
  output logic [15:0]       dout,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [FIFO_AW:0]  word_count,
  output logic [31:0]       frame_count,
  output logic              capture_done,
  output logic [2:0]        capture_state,
  output logic              err_short,
  output logic              err_long,
  output logic              err_overflow
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    IN_FRAME   = 3'd2,
    DONE       = 3'd3
  } state_t;

  localparam int                DEPTH      = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]  FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};

  // ---------------------------------------------------------------------
  // Input stage and edge detection
  // ---------------------------------------------------------------------
  logic       f_q, c_q;
  logic [7:0] d_q;
  logic       f_prev, c_prev;
  logic       strobe, frame_rise, frame_fall;

  generate
    if (SYNC_IN) begin : g_sync
      // Register the link inputs once before edge detection.
      always_ff @(posedge ti_clk or posedge rst) begin
        if (rst) begin
          f_q <= 1'b0;
          c_q <= 1'b0;
          d_q <= '0;
        end else begin
          // NOTE: non-blocking assignments for all sequential state so every
          // register samples the pre-edge value of its neighbours.
          f_q <= FRAME;
          c_q <= CCLK;
          d_q <= din;
        end
      end
    end else begin : g_raw
      assign f_q = FRAME;
      assign c_q = CCLK;
      assign d_q = din;
    end
  endgenerate

  // Previous-cycle copies of FRAME and CCLK for edge detection.
  always_ff @(posedge ti_clk or posedge rst) begin
    if (rst) begin
      f_prev <= 1'b0;
      c_prev <= 1'b0;
    end else begin
      f_prev <= f_q;
      c_prev <= c_q;
    end
  end

  assign strobe     = c_q & ~c_prev;
  assign frame_rise = f_q & ~f_prev;
  assign frame_fall = ~f_q & f_prev;

  // ---------------------------------------------------------------------
  // Capture FSM and byte packing
  // ---------------------------------------------------------------------
  state_t      state, state_next;
  logic [31:0] len, del;
  logic [31:0] byte_cnt, cnt_base, cnt_next;
  logic [7:0]  hi, hi_next;
  logic        pending, pend_base, pend_next;
  logic        wr_req, wr_en, rd_acc;
  logic [15:0] wr_word;
  logic        set_short, set_long, frame_end;

  // State register.
  always_ff @(posedge ti_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, byte acceptance, word assembly and frame-end bookkeeping.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    state_next = state;
    cnt_next   = byte_cnt;
    hi_next    = hi;
    pend_next  = pending;
    cnt_base   = byte_cnt;
    pend_base  = pending;
    wr_req     = 1'b0;
    wr_word    = '0;
    set_short  = 1'b0;
    set_long   = 1'b0;
    frame_end  = 1'b0;

    // A frame that opens this cycle starts from a clean byte counter.
    if (state == WAIT_FRAME) begin
      cnt_base  = '0;
      pend_base = 1'b0;
    end

    if (arm) begin
      state_next = WAIT_FRAME;
    end else if (state == IN_FRAME || (state == WAIT_FRAME && frame_rise)) begin
      state_next = IN_FRAME;
      cnt_next   = cnt_base;
      pend_next  = pend_base;

      // A coincident strobe is handled before the frame edge.
      if (strobe) begin
        if (cnt_base < len) begin
          if (pend_base) begin
            wr_req    = 1'b1;
            wr_word   = {hi, d_q};
            pend_next = 1'b0;
          end else begin
            hi_next   = d_q;
            pend_next = 1'b1;
          end
        end else begin
          set_long = 1'b1;
        end
        if (cnt_base != '1) cnt_next = cnt_base + 32'd1;
      end

      if (state == IN_FRAME && frame_fall) begin
        frame_end = 1'b1;
        if (cnt_next < len) set_short = 1'b1;
        // An odd byte count leaves a half word; flush it zero-padded.
        if (pend_next) begin
          wr_req    = 1'b1;
          wr_word   = {hi_next, 8'h00};
          pend_next = 1'b0;
        end
        state_next = (frame_count + 32'd1 == del) ? DONE : WAIT_FRAME;
      end
    end
  end

  // Capture datapath: config latch, counters, half-word holder, error flags.
  always_ff @(posedge ti_clk or posedge rst) begin
    if (rst) begin
      len          <= '0;
      del          <= '0;
      byte_cnt     <= '0;
      hi           <= '0;
      pending      <= 1'b0;
      frame_count  <= '0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      err_overflow <= 1'b0;
    end else if (arm) begin
      len          <= reg_length;
      del          <= (reg_delay == 32'd0) ? 32'd1 : reg_delay;
      byte_cnt     <= '0;
      hi           <= '0;
      pending      <= 1'b0;
      frame_count  <= '0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      byte_cnt <= cnt_next;
      hi       <= hi_next;
      pending  <= pend_next;
      if (frame_end)      frame_count  <= frame_count + 32'd1;
      if (set_short)      err_short    <= 1'b1;
      if (set_long)       err_long     <= 1'b1;
      if (wr_req && full) err_overflow <= 1'b1;
    end
  end

  assign capture_state = state;
  assign capture_done  = (state == DONE);

  // ---------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------
  logic [15:0]      mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;

  assign word_count = wr_ptr - rd_ptr;
  assign empty      = (word_count == '0);
  assign full       = (word_count == FULL_COUNT);
  assign wr_en      = wr_req & ~full;
  assign rd_acc     = rd_en & ~empty;

  // Storage array write port.
  always_ff @(posedge ti_clk) begin
    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, so clearing the array would buy nothing.
    if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= wr_word;
  end

  // Pointers and registered read port.
  always_ff @(posedge ti_clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      dout     <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr[FIFO_AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_frame_capture.sv
// Directed bench for frame_capture. A frame-level model turns each sent
// frame into the words, flags and counters it must produce; one compare
// process checks every word the DUT reads out against that model.
module tb_frame_capture;

  localparam int DEPTH = 64;

  logic        ti_clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0, arm_s = 1'b0;
  logic [31:0] reg_length = '0, reg_delay = '0;
  logic        FRAME = 1'b0, CCLK = 1'b0;
  logic [7:0]  din = '0;
  logic        rd_en = 1'b0, rd_en_s = 1'b0;

  logic [15:0] dout, dout_s;
  logic        rd_valid, empty, full, rd_valid_s, empty_s, full_s;
  logic [6:0]  word_count;
  logic [2:0]  word_count_s;
  logic [31:0] frame_count, frame_count_s;
  logic        capture_done, capture_done_s;
  logic [2:0]  capture_state, capture_state_s;
  logic        err_short, err_long, err_overflow;
  logic        err_short_s, err_long_s, err_overflow_s;

  always #5 ti_clk = ~ti_clk;

  frame_capture dut (
    .ti_clk(ti_clk), .rst(rst), .arm(arm),
    .reg_length(reg_length), .reg_delay(reg_delay),
    .FRAME(FRAME), .CCLK(CCLK), .din(din), .rd_en(rd_en),
    .dout(dout), .rd_valid(rd_valid), .empty(empty), .full(full),
    .word_count(word_count), .frame_count(frame_count),
    .capture_done(capture_done), .capture_state(capture_state),
    .err_short(err_short), .err_long(err_long), .err_overflow(err_overflow)
  );

  // Small-FIFO instance for the overflow scenario; shares the link inputs.
  frame_capture #(.FIFO_AW(2)) dut_s (
    .ti_clk(ti_clk), .rst(rst), .arm(arm_s),
    .reg_length(reg_length), .reg_delay(reg_delay),
    .FRAME(FRAME), .CCLK(CCLK), .din(din), .rd_en(rd_en_s),
    .dout(dout_s), .rd_valid(rd_valid_s), .empty(empty_s), .full(full_s),
    .word_count(word_count_s), .frame_count(frame_count_s),
    .capture_done(capture_done_s), .capture_state(capture_state_s),
    .err_short(err_short_s), .err_long(err_long_s), .err_overflow(err_overflow_s)
  );

  int errors = 0;
  int checks = 0;

  // Model state
  logic [15:0] exp_q[$];
  logic [7:0]  fb[64];
  int          m_len, m_del, m_frames;
  bit          m_short, m_long, m_ovf, m_done, m_active;
  int          mid_wc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ti_clk);
    #1;
  endtask

  task automatic model_arm(input int len, input int delay);
    m_len    = len;
    m_del    = (delay == 0) ? 1 : delay;
    m_frames = 0;
    m_short  = 0;
    m_long   = 0;
    m_ovf    = 0;
    m_done   = 0;
    m_active = 1;
  endtask

  // What one frame of n bytes (fb[off..]) must leave behind.
  task automatic model_frame(input int off, input int n);
    int acc;
    logic [15:0] w;
    if (!m_active) return;
    acc = (n < m_len) ? n : m_len;
    for (int i = 0; i < acc; i += 2) begin
      w[15:8] = fb[off + i];
      w[7:0]  = (i + 1 < acc) ? fb[off + i + 1] : 8'h00;
      if (exp_q.size() < DEPTH) exp_q.push_back(w);
      else m_ovf = 1;
    end
    if (n < m_len) m_short = 1;
    if (n > m_len) m_long = 1;
    m_frames++;
    if (m_frames == m_del) begin
      m_done   = 1;
      m_active = 0;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_word_count"}, 32'(word_count), exp_q.size());
    check({tag, "_frame_count"}, frame_count, m_frames);
    check({tag, "_capture_done"}, 32'(capture_done), 32'(m_done));
    check({tag, "_err_short"}, 32'(err_short), 32'(m_short));
    check({tag, "_err_long"}, 32'(err_long), 32'(m_long));
    check({tag, "_err_overflow"}, 32'(err_overflow), 32'(m_ovf));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_dout"}, 32'(dout), 0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_full"}, 32'(full), 0);
    check({tag, "_word_count"}, 32'(word_count), 0);
    check({tag, "_frame_count"}, frame_count, 0);
    check({tag, "_capture_done"}, 32'(capture_done), 0);
    check({tag, "_capture_state"}, 32'(capture_state), 0);
    check({tag, "_err_short"}, 32'(err_short), 0);
    check({tag, "_err_long"}, 32'(err_long), 0);
    check({tag, "_err_overflow"}, 32'(err_overflow), 0);
  endtask

  task automatic do_arm(input int len, input int delay);
    reg_length = len;
    reg_delay  = delay;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    model_arm(len, delay);
  endtask

  // cs/ce: first/last CCLK rise coincides with FRAME rise/fall.
  // rd_at: byte index during whose FIFO write the host also reads (-1 none).
  task automatic send_frame(input int off, input int n, input bit cs, input bit ce, input int rd_at);
    if (!cs) begin
      FRAME = 1'b1;
      tick();
      tick();
    end
    for (int i = 0; i < n; i++) begin
      din  = fb[off + i];
      CCLK = 1'b1;
      if (cs && i == 0) FRAME = 1'b1;
      if (ce && i == n - 1) FRAME = 1'b0;
      tick();
      if (i == rd_at) begin
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        mid_wc = int'(word_count);
      end else begin
        tick();
      end
      CCLK = 1'b0;
      tick();
      tick();
    end
    FRAME = 1'b0;
    repeat (4) tick();
    model_frame(off, n);
  endtask

  task automatic drain(input string tag);
    int n = exp_q.size();
    repeat (n) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      tick();
    end
    @(negedge ti_clk);
    check({tag, "_drain_all_read"}, exp_q.size(), 0);
    check({tag, "_drain_empty"}, 32'(empty), 1);
  endtask

  // Compare process: every word the DUT presents must be the model's next.
  always @(negedge ti_clk) begin
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) check("rd_valid_unexpected", 32'(rd_valid), 0);
      else check("dout_word", 32'(dout), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    m_active = 0;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge ti_clk);
    check_reset("reset");
    rst = 1'b0;
    tick();

    // Nominal: 3 frames of 8 bytes, 0x01..0x18
    do_arm(8, 3);
    for (int i = 0; i < 24; i++) fb[i] = 8'(i + 1);
    for (int f = 0; f < 3; f++) send_frame(f * 8, 8, 0, 0, -1);
    check_model("nominal");
    check("nominal_model_first", 32'(exp_q[0]), 32'h0102);
    check("nominal_model_last", 32'(exp_q[11]), 32'h1718);
    check("nominal_word_count", 32'(word_count), 12);
    check("nominal_state", 32'(capture_state), 3);
    drain("nominal");

    // Odd length
    do_arm(5, 1);
    fb[0] = 8'hAA; fb[1] = 8'hBB; fb[2] = 8'hCC; fb[3] = 8'hDD; fb[4] = 8'hEE;
    send_frame(0, 5, 0, 0, -1);
    check_model("odd");
    check("odd_word_count", 32'(word_count), 3);
    check("odd_model_pad", 32'(exp_q[2]), 32'hEE00);
    drain("odd");

    // Short then long frame
    do_arm(4, 2);
    for (int i = 0; i < 3; i++) fb[i] = 8'(8'h31 + i);
    send_frame(0, 3, 0, 0, -1);
    check_model("short");
    check("short_err", 32'(err_short), 1);
    check("short_state", 32'(capture_state), 1);
    for (int i = 0; i < 6; i++) fb[i] = 8'(8'h41 + i);
    send_frame(0, 6, 0, 0, -1);
    check_model("long");
    check("long_word_count", 32'(word_count), 4);
    drain("shortlong");

    // CCLK rise coincident with FRAME rise and with FRAME fall
    do_arm(4, 1);
    for (int i = 0; i < 4; i++) fb[i] = 8'(8'h51 + i);
    send_frame(0, 4, 1, 1, -1);
    check_model("coincide");
    check("coincide_no_short", 32'(err_short), 0);

    // Read and write in the same cycle with two words held
    do_arm(4, 1);
    for (int i = 0; i < 4; i++) fb[i] = 8'(8'h61 + i);
    send_frame(0, 4, 0, 0, 1);
    check("simul_rw_word_count", mid_wc, 2);
    check_model("simul_rw");
    drain("simul_rw");

    // Zero length with zero delay (treated as one frame)
    do_arm(0, 0);
    fb[0] = 8'h71; fb[1] = 8'h72;
    send_frame(0, 2, 0, 0, -1);
    check_model("zero_len");
    check("zero_len_long", 32'(err_long), 1);

    // Read while empty
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    @(negedge ti_clk);
    check("empty_read_no_valid", 32'(rd_valid), 0);

    // Reset mid-frame, then a clean capture
    do_arm(8, 1);
    for (int i = 0; i < 8; i++) fb[i] = 8'(8'h81 + i);
    FRAME = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      din = fb[i];
      CCLK = 1'b1;
      tick(); tick();
      CCLK = 1'b0;
      tick(); tick();
    end
    rst = 1'b1;
    exp_q.delete();
    m_active = 0;
    @(negedge ti_clk);
    check_reset("midrst");
    FRAME = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    do_arm(8, 1);
    send_frame(0, 8, 0, 0, -1);
    check_model("rearm");
    check("rearm_word_count", 32'(word_count), 4);
    drain("rearm");

    // Overflow on the 4-word instance (main instance sits in DONE)
    reg_length = 16;
    reg_delay  = 1;
    arm_s = 1'b1;
    tick();
    arm_s = 1'b0;
    for (int i = 0; i < 16; i++) fb[i] = 8'(8'h10 + i);
    send_frame(0, 16, 0, 0, -1);
    check("ovf_word_count", 32'(word_count_s), 4);
    check("ovf_full", 32'(full_s), 1);
    check("ovf_err", 32'(err_overflow_s), 1);
    check("ovf_frame_count", frame_count_s, 1);
    check("ovf_done", 32'(capture_done_s), 1);
    check("ovf_no_short", 32'(err_short_s), 0);
    check("ovf_no_long", 32'(err_long_s), 0);
    check("ovf_main_untouched", 32'(word_count), 0);
    for (int i = 0; i < 4; i++) begin
      rd_en_s = 1'b1;
      tick();
      rd_en_s = 1'b0;
      @(negedge ti_clk);
      check("ovf_rd_valid", 32'(rd_valid_s), 1);
      check("ovf_dout", 32'(dout_s), 32'({fb[2 * i], fb[2 * i + 1]}));
      tick();
    end
    check("ovf_empty_after", 32'(empty_s), 1);
    rd_en_s = 1'b1;
    tick();
    rd_en_s = 1'b0;
    @(negedge ti_clk);
    check("ovf_empty_read_no_valid", 32'(rd_valid_s), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
